// File: rtl/drv_segment_pkg.sv
// Shared definitions for the 7-segment display bus capture block.
// Segment patterns are active-low, written {middle, top-left, bottom-left, bottom, bottom-right, top-right, top}.
package drv_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [3:0] val;
    logic       blank;
    logic       err;
  } seg_result_t;

endpackage

// File: rtl/drv_segment_pattern_dec.sv
// Combinational segment pattern -> {val, blank, err} decoder.
// Hex letters A-F decode only when DRV_SEGMENT_HEX_EN is defined; otherwise they are errors.
module drv_segment_pattern_dec
  import drv_segment_pkg::*;
(
  input  logic [6:0] sgmnt,
  output logic [3:0] val_c,
  output logic       blank_c,
  output logic       err_c
);

  seg_result_t res;

  always_comb begin
    res = '{val: 4'hF, blank: 1'b0, err: 1'b1};
    case (sgmnt)
      SEG_0:     res = '{val: 4'd0, blank: 1'b0, err: 1'b0};
      SEG_1:     res = '{val: 4'd1, blank: 1'b0, err: 1'b0};
      SEG_2:     res = '{val: 4'd2, blank: 1'b0, err: 1'b0};
      SEG_3:     res = '{val: 4'd3, blank: 1'b0, err: 1'b0};
      SEG_4:     res = '{val: 4'd4, blank: 1'b0, err: 1'b0};
      SEG_5:     res = '{val: 4'd5, blank: 1'b0, err: 1'b0};
      SEG_6:     res = '{val: 4'd6, blank: 1'b0, err: 1'b0};
      SEG_7:     res = '{val: 4'd7, blank: 1'b0, err: 1'b0};
      SEG_8:     res = '{val: 4'd8, blank: 1'b0, err: 1'b0};
      SEG_9:     res = '{val: 4'd9, blank: 1'b0, err: 1'b0};
      SEG_BLANK: res = '{val: 4'd0, blank: 1'b1, err: 1'b0};
`ifdef DRV_SEGMENT_HEX_EN
      SEG_A:     res = '{val: 4'd10, blank: 1'b0, err: 1'b0};
      SEG_B:     res = '{val: 4'd11, blank: 1'b0, err: 1'b0};
      SEG_C:     res = '{val: 4'd12, blank: 1'b0, err: 1'b0};
      SEG_D:     res = '{val: 4'd13, blank: 1'b0, err: 1'b0};
      SEG_E:     res = '{val: 4'd14, blank: 1'b0, err: 1'b0};
      SEG_F:     res = '{val: 4'd15, blank: 1'b0, err: 1'b0};
`endif
      default: ;
    endcase
  end

  assign val_c   = res.val;
  assign blank_c = res.blank;
  assign err_c   = res.err;

endmodule

// File: rtl/drv_segment_capture.sv
// Recovers per-digit values from a multiplexed active-low 7-segment bus, with a stability
// filter and a valid/ready update channel. Build option: DRV_SEGMENT_HEX_EN (hex letter decode).
module drv_segment_capture
  import drv_segment_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [6:0]                 i_sgmnt,
  input  logic [DIGITS-1:0]          i_an,
  output logic [4*DIGITS-1:0]        o_val,
  output logic [DIGITS-1:0]          o_blank,
  output logic [DIGITS-1:0]          o_err,
  output logic                       o_upd_valid,
  output logic [$clog2(DIGITS)-1:0]  o_upd_idx,
  input  logic                       i_upd_ready
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SW = DIGITS + 7;

  logic [SW-1:0]     sync1, sync2, prev;
  cap_state_t        state;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] pend, pend_next, set_mask, clr_mask;
  logic [IW-1:0]     dig_idx, low_idx;
  logic [DIGITS-1:0] an_s;
  logic [6:0]        sg_s;
  logic              an_ok, same, capture, changed;
  logic [3:0]        dec_val;
  logic              dec_blank, dec_err;

  assign an_s  = sync2[SW-1:7];
  assign sg_s  = sync2[6:0];
  assign an_ok = $onehot(~an_s);
  assign same  = (sync2 == prev);

  drv_segment_pattern_dec u_dec (
    .sgmnt   (sg_s),
    .val_c   (dec_val),
    .blank_c (dec_blank),
    .err_c   (dec_err)
  );

  // Index of the driven (low) anode; only meaningful when an_ok.
  always_comb begin
    dig_idx = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (!an_s[i]) dig_idx = IW'(i);
    end
  end

  // A capture happens on the sample that completes STABLE_CYCLES identical samples.
  assign capture = (state == SETTLE) && an_ok && same && (cnt == CW'(STABLE_CYCLES - 1));
  assign changed = capture &&
                   ({dec_val, dec_blank, dec_err} !=
                    {o_val[4*dig_idx +: 4], o_blank[dig_idx], o_err[dig_idx]});

  // Pending mask update: a set on the same bit as a handshake clear wins.
  always_comb begin
    set_mask  = changed ? (DIGITS'(1) << dig_idx) : '0;
    clr_mask  = (o_upd_valid && i_upd_ready) ? (DIGITS'(1) << o_upd_idx) : '0;
    pend_next = (pend & ~clr_mask) | set_mask;
    low_idx   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (pend_next[i]) low_idx = IW'(i);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1       <= '1;
      sync2       <= '1;
      prev        <= '1;
      state       <= WAIT;
      cnt         <= '0;
      o_val       <= '0;
      o_blank     <= '1;
      o_err       <= '0;
      pend        <= '0;
      o_upd_valid <= 1'b0;
      o_upd_idx   <= '0;
    end else begin
      sync1       <= {i_an, i_sgmnt};
      sync2       <= sync1;
      prev        <= sync2;
      pend        <= pend_next;
      o_upd_valid <= |pend_next;
      o_upd_idx   <= low_idx;

      if (changed) begin
        o_val[4*dig_idx +: 4] <= dec_val;
        o_blank[dig_idx]      <= dec_blank;
        o_err[dig_idx]        <= dec_err;
      end

      if (!an_ok) begin
        state <= WAIT;
        cnt   <= '0;
      end else begin
        case (state)
          WAIT: begin
            state <= SETTLE;
            cnt   <= CW'(1);
          end
          SETTLE: begin
            if (!same) begin
              cnt <= CW'(1);
            end else if (capture) begin
              state <= HOLD;
              cnt   <= CW'(STABLE_CYCLES);
            end else if (cnt < CW'(STABLE_CYCLES)) begin
              cnt <= cnt + CW'(1);
            end
          end
          HOLD: begin
            if (!same) begin
              state <= SETTLE;
              cnt   <= CW'(1);
            end
          end
          default: begin
            state <= WAIT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drv_segment_capture.sv
// Directed self-checking bench for drv_segment_capture (DIGITS=4, STABLE_CYCLES=16).
// Honours DRV_SEGMENT_HEX_EN for the hex-letter expectations.
module tb_drv_segment_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  sgmnt;
  logic [3:0]  an;
  logic [15:0] val;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        upd_valid;
  logic [1:0]  upd_idx;
  logic        upd_ready;

  int nvec = 0;
  int nerr = 0;

  localparam logic [6:0] P_1 = 7'b1111001;
  localparam logic [6:0] P_2 = 7'b0100100;
  localparam logic [6:0] P_3 = 7'b0110000;
  localparam logic [6:0] P_4 = 7'b0011001;
  localparam logic [6:0] P_5 = 7'b0010010;
  localparam logic [6:0] P_6 = 7'b0000010;
  localparam logic [6:0] P_7 = 7'b1111000;
  localparam logic [6:0] P_8 = 7'b0000000;
  localparam logic [6:0] P_9 = 7'b0010000;
  localparam logic [6:0] P_A = 7'b0001000;
  localparam logic [6:0] P_BL = 7'b1111111;

  drv_segment_capture #(.DIGITS(4), .STABLE_CYCLES(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sgmnt     (sgmnt),
    .i_an        (an),
    .o_val       (val),
    .o_blank     (blank),
    .o_err       (err),
    .o_upd_valid (upd_valid),
    .o_upd_idx   (upd_idx),
    .i_upd_ready (upd_ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    upd_ready = 1'b1;
    tick(1);
    upd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_ready = 1'b0; an = 4'b1111; sgmnt = P_BL;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_val",   32'(val),       32'h0);
    chk("reset_blank", 32'(blank),     32'hF);
    chk("reset_err",   32'(err),       32'h0);
    chk("reset_valid", 32'(upd_valid), 32'h0);
    chk("reset_idx",   32'(upd_idx),   32'h0);

    // Single capture on digit 1: visible after exactly 18 edges
    an = 4'b1101; sgmnt = P_2;
    tick(17);
    chk("lat_not_yet", 32'(upd_valid), 32'h0);
    chk("lat_val_old", 32'(val),       32'h0);
    tick(1);
    chk("cap_val",   32'(val),       32'h0020);
    chk("cap_blank", 32'(blank),     32'b1101);
    chk("cap_err",   32'(err),       32'h0);
    chk("cap_valid", 32'(upd_valid), 32'h1);
    chk("cap_idx",   32'(upd_idx),   32'h1);
    tick(10);
    chk("hold_valid", 32'(upd_valid), 32'h1);
    chk("hold_idx",   32'(upd_idx),   32'h1);
    handshake();
    chk("hs_drop", 32'(upd_valid), 32'h0);
    tick(20);
    chk("no_recapture", 32'(upd_valid), 32'h0);

    // Glitch rejection on digit 0: pattern never stable for 16 samples
    an = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      sgmnt = i[0] ? P_4 : P_3;
      tick(10);
      chk("glitch_valid", 32'(upd_valid), 32'h0);
    end
    an = 4'b1111;
    tick(4);
    chk("glitch_val",   32'(val),   32'h0020);
    chk("glitch_blank", 32'(blank), 32'b1101);

    // Invalid anode patterns: nothing captured
    an = 4'b1111; sgmnt = P_5;
    tick(30);
    chk("inv_all_valid", 32'(upd_valid), 32'h0);
    chk("inv_all_val",   32'(val),       32'h0020);
    an = 4'b0011;
    tick(30);
    chk("inv_two_valid", 32'(upd_valid), 32'h0);
    chk("inv_two_val",   32'(val),       32'h0020);
    chk("inv_two_blank", 32'(blank),     32'b1101);

    // Full scan: back-to-back changes on digits 0, 1, 3; digit 2 blank reconfirmed
    an = 4'b1110; sgmnt = P_7;  tick(20);
    an = 4'b1101; sgmnt = P_1;  tick(20);
    an = 4'b1011; sgmnt = P_BL; tick(20);
    an = 4'b0111; sgmnt = P_A;  tick(20);
`ifdef DRV_SEGMENT_HEX_EN
    chk("scan_val", 32'(val), 32'hA017);
    chk("scan_err", 32'(err), 32'h0);
`else
    chk("scan_val", 32'(val), 32'hF017);
    chk("scan_err", 32'(err), 32'b1000);
`endif
    chk("scan_blank", 32'(blank),     32'b0100);
    chk("scan_valid", 32'(upd_valid), 32'h1);
    chk("scan_idx0",  32'(upd_idx),   32'h0);
    handshake();
    chk("scan_idx1",  32'(upd_idx),   32'h1);
    chk("scan_v1",    32'(upd_valid), 32'h1);
    handshake();
    chk("scan_idx3",  32'(upd_idx),   32'h3);
    chk("scan_v3",    32'(upd_valid), 32'h1);
    handshake();
    chk("scan_done",  32'(upd_valid), 32'h0);

    // Coalescing: two changes to digit 0 while pending give one update
    an = 4'b1110; sgmnt = P_8; tick(20);
    chk("coal_first_val", 32'(val[3:0]), 32'h8);
    chk("coal_first_v",   32'(upd_valid), 32'h1);
    sgmnt = P_9; tick(20);
    chk("coal_val",   32'(val[3:0]), 32'h9);
    chk("coal_idx",   32'(upd_idx),  32'h0);
    chk("coal_valid", 32'(upd_valid), 32'h1);
    handshake();
    chk("coal_one_hs", 32'(upd_valid), 32'h0);

    // Same-cycle set and clear of bit 0: set wins
    sgmnt = P_6; tick(18);
    chk("sc_pend", 32'(upd_valid), 32'h1);
    sgmnt = P_5; tick(17);
    chk("sc_pre_val", 32'(val[3:0]), 32'h6);
    handshake();
    chk("sc_val",   32'(val[3:0]), 32'h5);
    chk("sc_valid", 32'(upd_valid), 32'h1);
    chk("sc_idx",   32'(upd_idx),   32'h0);
    handshake();
    chk("sc_clear", 32'(upd_valid), 32'h0);

    // Reset mid-operation discards a pending update immediately
    an = 4'b1011; sgmnt = P_3; tick(18);
    chk("mid_pend", 32'(upd_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_val",   32'(val),       32'h0);
    chk("mid_rst_blank", 32'(blank),     32'hF);
    chk("mid_rst_err",   32'(err),       32'h0);
    chk("mid_rst_valid", 32'(upd_valid), 32'h0);
    an = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("post_rst_valid", 32'(upd_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
